// File: rtl/axi_rd_arbiter.sv
// Two-requester (IFU/LSU) AXI read arbiter, one outstanding transaction, round-robin grant.
// Grant is combinational in IDLE; the address is registered and presented in the following cycle.
module axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              ifu_arvalid,
  input  logic [ADDR_W-1:0] ifu_araddr,
  output logic              ifu_arready,
  output logic              ifu_rvalid,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic [1:0]        ifu_rresp,
  input  logic              ifu_rready,
  input  logic              ifu_flush,

  input  logic              lsu_arvalid,
  input  logic [ADDR_W-1:0] lsu_araddr,
  output logic              lsu_arready,
  output logic              lsu_rvalid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic [1:0]        lsu_rresp,
  input  logic              lsu_rready,

  output logic              m_arvalid,
  output logic [ADDR_W-1:0] m_araddr,
  input  logic              m_arready,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  output logic              m_rready
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t              state_q;
  logic                gnt_lsu_q;
  logic                pref_lsu_q;
  logic                drop_q;
  logic                arvalid_q;
  logic [ADDR_W-1:0]   araddr_q;

  logic                ifu_req;
  logic                pick_lsu;
  logic                in_idle;
  logic                in_data;
  logic                drop_now;

  // A flushed IFU request is invisible to the arbiter in the cycle it is raised.
  assign ifu_req  = ifu_arvalid & ~ifu_flush;
  assign pick_lsu = lsu_arvalid & (pref_lsu_q | ~ifu_req);
  assign in_idle  = (state_q == IDLE);
  assign in_data  = (state_q == DATA);

  assign ifu_arready = in_idle & ifu_req & ~pick_lsu;
  assign lsu_arready = in_idle & pick_lsu;

  // A flush arriving in the same cycle as the beat also discards it.
  assign drop_now = ~gnt_lsu_q & (drop_q | ifu_flush);

  assign ifu_rvalid = in_data & ~gnt_lsu_q & ~drop_now & m_rvalid;
  assign lsu_rvalid = in_data &  gnt_lsu_q & m_rvalid;
  assign m_rready   = in_data & (gnt_lsu_q ? lsu_rready : (drop_now | ifu_rready));

  assign ifu_rdata = m_rdata;
  assign lsu_rdata = m_rdata;
  assign ifu_rresp = m_rresp;
  assign lsu_rresp = m_rresp;

  assign m_arvalid = arvalid_q;
  assign m_araddr  = araddr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_lsu_q  <= 1'b0;
      pref_lsu_q <= 1'b1;
      drop_q     <= 1'b0;
      arvalid_q  <= 1'b0;
      araddr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ifu_arready | lsu_arready) begin
            state_q   <= ADDR;
            gnt_lsu_q <= pick_lsu;
            araddr_q  <= pick_lsu ? lsu_araddr : ifu_araddr;
            arvalid_q <= 1'b1;
            drop_q    <= 1'b0;
          end
        end
        ADDR: begin
          drop_q <= drop_q | (ifu_flush & ~gnt_lsu_q);
          if (m_arready) begin
            arvalid_q <= 1'b0;
            state_q   <= DATA;
          end
        end
        DATA: begin
          drop_q <= drop_q | (ifu_flush & ~gnt_lsu_q);
          if (m_rvalid & m_rready) begin
            state_q    <= IDLE;
            pref_lsu_q <= ~gnt_lsu_q;
            drop_q     <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          arvalid_q <= 1'b0;
          drop_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule
